// File: rtl/imem_fetch_sequencer_pkg.sv
// Shared constants, FSM state type and opcode helper for the instruction-memory
// fetch sequencer.
package imem_fetch_sequencer_pkg;

  localparam int DATA_W     = 32;
  localparam int IMEM_DEPTH = 32;
  localparam int IMEM_AW    = $clog2(IMEM_DEPTH);

  localparam logic [5:0] OPC_J   = 6'b000010;
  localparam logic [5:0] OPC_BEQ = 6'b000100;

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  function automatic logic is_jump(input logic [5:0] opc);
    return opc == OPC_J;
  endfunction

endpackage

// File: rtl/imem_fetch_sequencer_if.sv
// Bundle of the loader, instruction-memory and datapath-control signals.
// master = sequencer side, slave = loader/memory/datapath side.
interface imem_fetch_sequencer_if
  import imem_fetch_sequencer_pkg::*;
#(
  parameter int N  = DATA_W,
  parameter int AW = IMEM_AW
);

  logic          load_valid;
  logic [N-1:0]  load_data;
  logic          load_last;
  logic          load_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [N-1:0]  imem_wdata;
  logic [N-1:0]  imem_addr;
  logic [N-1:0]  instr_in;
  logic          stall;
  logic          branch_taken;
  logic          reload;
  logic          run;
  logic          halted;
  logic [N-1:0]  pc;
  logic [N-1:0]  instr_count;

  modport master (
    input  load_valid, load_data, load_last, instr_in, stall, branch_taken, reload,
    output load_ready, imem_we, imem_waddr, imem_wdata, imem_addr,
           run, halted, pc, instr_count
  );

  modport slave (
    output load_valid, load_data, load_last, instr_in, stall, branch_taken, reload,
    input  load_ready, imem_we, imem_waddr, imem_wdata, imem_addr,
           run, halted, pc, instr_count
  );

endinterface

// File: rtl/imem_fetch_sequencer_next_pc.sv
// Combinational next-PC selection (J > taken BEQ > sequential) and
// jump-to-self halt detection.
module imem_fetch_sequencer_next_pc
  import imem_fetch_sequencer_pkg::*;
#(
  parameter int N  = DATA_W,
  parameter int AW = IMEM_AW
) (
  input  logic [AW-1:0] pc_i,
  input  logic [N-1:0]  instr_i,
  input  logic          branch_taken_i,
  output logic [AW-1:0] next_pc_o,
  output logic          halt_o
);

  logic          is_j_s;
  logic [AW-1:0] target_s;
  logic [AW-1:0] seq_s;
  logic [AW-1:0] br_s;
  logic          unused_s;

  assign is_j_s   = is_jump(instr_i[N-1:N-6]);
  assign target_s = instr_i[AW-1:0];
  assign seq_s    = pc_i + AW'(1);
  // Offset bits above AW only reach bits that truncation to AW discards,
  // so adding the low AW bits equals pc+1+sext(imm) mod DEPTH.
  assign br_s     = seq_s + instr_i[AW-1:0];
  assign unused_s = ^instr_i[N-7:AW];

  assign halt_o = is_j_s && (target_s == pc_i);

  // Select the successor PC by instruction priority.
  always_comb begin
    next_pc_o = seq_s;
    if (is_j_s) begin
      next_pc_o = target_s;
    end else if (branch_taken_i) begin
      next_pc_o = br_s;
    end else begin
      next_pc_o = seq_s;
    end
  end

endmodule

// File: rtl/imem_fetch_sequencer.sv
// Loads a program into instruction memory over a valid/ready port, then owns
// the PC: sequential fetch, BEQ, J, stall, halt on jump-to-self, reload.
module imem_fetch_sequencer
  import imem_fetch_sequencer_pkg::*;
#(
  parameter int N     = DATA_W,
  parameter int DEPTH = IMEM_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  imem_fetch_sequencer_if.master bus
);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] waddr_q;
  logic [N-1:0]  count_q;
  logic          run_q;
  logic          halted_q;
  logic          load_ready_q;

  logic [AW-1:0] next_pc_d;
  logic          halt_d;
  logic          beat_s;
  logic          load_done_s;

  imem_fetch_sequencer_next_pc #(
    .N  (N),
    .AW (AW)
  ) u_next_pc (
    .pc_i           (pc_q),
    .instr_i        (bus.instr_in),
    .branch_taken_i (bus.branch_taken),
    .next_pc_o      (next_pc_d),
    .halt_o         (halt_d)
  );

  assign beat_s      = bus.load_valid & load_ready_q;
  assign load_done_s = bus.load_last || (waddr_q == AW'(DEPTH - 1));

  assign bus.load_ready  = load_ready_q;
  assign bus.imem_we     = beat_s;
  assign bus.imem_waddr  = waddr_q;
  assign bus.imem_wdata  = bus.load_data;
  assign bus.imem_addr   = {{(N - AW){1'b0}}, pc_q};
  assign bus.pc          = {{(N - AW){1'b0}}, pc_q};
  assign bus.run         = run_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = count_q;

  // Sequencer FSM with its counters and registered status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_LOAD;
      pc_q         <= '0;
      waddr_q      <= '0;
      count_q      <= '0;
      run_q        <= 1'b0;
      halted_q     <= 1'b0;
      load_ready_q <= 1'b1;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (beat_s) begin
            if (load_done_s) begin
              state_q      <= ST_RUN;
              run_q        <= 1'b1;
              load_ready_q <= 1'b0;
              pc_q         <= '0;
              count_q      <= '0;
              waddr_q      <= '0;
            end else begin
              waddr_q <= waddr_q + AW'(1);
            end
          end
        end
        ST_RUN: begin
          if (bus.reload) begin
            state_q      <= ST_LOAD;
            run_q        <= 1'b0;
            halted_q     <= 1'b0;
            load_ready_q <= 1'b1;
            waddr_q      <= '0;
          end else if (!bus.stall) begin
            count_q <= count_q + N'(1);
            // The jump-to-self retires, then the PC freezes on it.
            if (halt_d) begin
              state_q  <= ST_HALT;
              run_q    <= 1'b0;
              halted_q <= 1'b1;
            end else begin
              pc_q <= next_pc_d;
            end
          end
        end
        ST_HALT: begin
          if (bus.reload) begin
            state_q      <= ST_LOAD;
            run_q        <= 1'b0;
            halted_q     <= 1'b0;
            load_ready_q <= 1'b1;
            waddr_q      <= '0;
          end
        end
        default: begin
          state_q      <= ST_LOAD;
          run_q        <= 1'b0;
          halted_q     <= 1'b0;
          load_ready_q <= 1'b1;
          waddr_q      <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Directed bench for imem_fetch_sequencer: load sequences, a table of run
// cycles, and hand-written BEQ wrap and asynchronous reset sequences.
module tb_imem_fetch_sequencer;
  import imem_fetch_sequencer_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  logic [31:0] mem [32];

  imem_fetch_sequencer_if #(.N(32), .AW(5)) bus ();

  imem_fetch_sequencer #(.N(32), .DEPTH(32), .AW(5)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
  end
  assign bus.instr_in = mem[bus.imem_addr[4:0]];

  typedef struct {
    logic stall;
    logic br;
    logic reload;
    int   pc;
    int   cnt;
    logic run;
    logic halted;
    logic ready;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  // Offer one load word after 'gap' idle cycles; time is posedge+1 on entry and exit.
  task automatic load_word(input logic [31:0] d, input logic last, input int gap,
                           input logic rl, input int exp_waddr);
    for (int g = 0; g < gap; g++) begin
      bus.load_valid = 1'b0;
      #1;
      check("idle_we", 32'(bus.imem_we), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
    bus.reload     = rl;
    #1;
    check("beat_we", 32'(bus.imem_we), 32'd1);
    check("beat_waddr", 32'(bus.imem_waddr), 32'(exp_waddr));
    check("beat_wdata", bus.imem_wdata, d);
    @(posedge clk);
    #1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.reload     = 1'b0;
  endtask

  function automatic logic [31:0] prog_a(input int i);
    logic [31:0] w;
    w = 32'h0000_0020 + 32'(i);
    if (i == 4) w = {OPC_BEQ, 5'd1, 5'd2, 16'hFFFD};
    if (i == 5) w = {OPC_J, 26'd9};
    if (i == 9) w = {OPC_J, 26'd9};
    return w;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b1;
    bus.load_valid   = 1'b0;
    bus.load_data    = 32'd0;
    bus.load_last    = 1'b0;
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.reload       = 1'b0;

    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1, 1,  1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 2, 2,  1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 2, 2,  1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 2, 2,  1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b0, 3, 3,  1'b1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4, 4,  1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 2, 5,  1'b1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 3, 6,  1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 4, 7,  1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 5, 8,  1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 9, 9,  1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 9, 9,  1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 9, 10, 1'b0, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b0, 9, 10, 1'b0, 1'b1, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b1, 9, 10, 1'b0, 1'b0, 1'b1};

    // Reset state
    #2;
    check("rst_ready", 32'(bus.load_ready), 32'd1);
    check("rst_run", 32'(bus.run), 32'd0);
    check("rst_halted", 32'(bus.halted), 32'd0);
    check("rst_pc", bus.pc, 32'd0);
    check("rst_count", bus.instr_count, 32'd0);
    check("rst_we", 32'(bus.imem_we), 32'd0);
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Three-word load with gaps; reload during LOAD is ignored
    load_word(32'hAAAA_0001, 1'b0, 1, 1'b0, 0);
    load_word(32'hBBBB_0002, 1'b0, 2, 1'b1, 1);
    check("l3_still_load", 32'(bus.load_ready), 32'd1);
    load_word(32'hCCCC_0003, 1'b1, 0, 1'b0, 2);
    check("l3_run", 32'(bus.run), 32'd1);
    check("l3_pc", bus.pc, 32'd0);
    check("l3_ready", 32'(bus.load_ready), 32'd0);
    check("l3_count", bus.instr_count, 32'd0);
    check("l3_mem0", mem[0], 32'hAAAA_0001);
    check("l3_mem1", mem[1], 32'hBBBB_0002);
    check("l3_mem2", mem[2], 32'hCCCC_0003);

    // Full-depth load without load_last
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 32; i++) begin
      load_word(prog_a(i), 1'b0, 0, 1'b0, i);
      if (i == 30) check("l32_before_last", 32'(bus.run), 32'd0);
    end
    check("l32_run", 32'(bus.run), 32'd1);
    check("l32_pc", bus.pc, 32'd0);
    check("l32_waddr", 32'(bus.imem_waddr), 32'd0);
    check("l32_ready", 32'(bus.load_ready), 32'd0);

    // Table-driven run: stalls, BEQ back, J, jump-to-self halt, reload
    for (int r = 0; r < 15; r++) begin
      bus.stall        = tbl[r].stall;
      bus.branch_taken = tbl[r].br;
      bus.reload       = tbl[r].reload;
      @(posedge clk);
      #1;
      check($sformatf("row%0d_pc", r), bus.pc, 32'(tbl[r].pc));
      check($sformatf("row%0d_addr", r), bus.imem_addr, 32'(tbl[r].pc));
      check($sformatf("row%0d_count", r), bus.instr_count, 32'(tbl[r].cnt));
      check($sformatf("row%0d_run", r), 32'(bus.run), 32'(tbl[r].run));
      check($sformatf("row%0d_halted", r), 32'(bus.halted), 32'(tbl[r].halted));
      check($sformatf("row%0d_ready", r), 32'(bus.load_ready), 32'(tbl[r].ready));
    end
    bus.stall        = 1'b0;
    bus.branch_taken = 1'b0;
    bus.reload       = 1'b0;

    // BEQ wrap (4+1+31 = 36 -> 4), then async reset mid-RUN at pc=6
    do_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      load_word((i == 4) ? {OPC_BEQ, 5'd3, 5'd3, 16'h001F} : 32'h0000_0040 + 32'(i),
                (i == 7) ? 1'b1 : 1'b0, 0, 1'b0, i);
    end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
    end
    check("wrap_pc_before", bus.pc, 32'd4);
    bus.branch_taken = 1'b1;
    @(posedge clk);
    #1;
    bus.branch_taken = 1'b0;
    check("wrap_pc", bus.pc, 32'd4);
    check("wrap_count", bus.instr_count, 32'd5);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("pre_rst_pc", bus.pc, 32'd6);
    #2;
    rst = 1'b1;
    #1;
    check("arst_pc", bus.pc, 32'd0);
    check("arst_run", 32'(bus.run), 32'd0);
    check("arst_ready", 32'(bus.load_ready), 32'd1);
    check("arst_count", bus.instr_count, 32'd0);
    check("arst_halted", 32'(bus.halted), 32'd0);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
